// File: rtl/elevator_request_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator request scheduler and the elevator
// state machine it drives: floor-number width, scheduler state encoding and
// SCAN direction encoding.
// ---------------------------------------------------------------------------
package elevator_pkg;

    localparam int FLOOR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        DWELL = 2'b10
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/elevator_request_scheduler_button_sync_edge.sv
// ---------------------------------------------------------------------------
// button_sync_edge
// Two-flop synchronizer per button bit followed by a rising-edge detector.
//
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   i_btn   - raw asynchronous button levels
//   o_rise  - one-cycle pulse per bit on a synchronized 0->1 transition
// ---------------------------------------------------------------------------
module button_sync_edge #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;
    logic [2:0]       r_arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
            r_arm  <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_arm  <= {r_arm[1:0], 1'b1};
        end
    end

    // The pipeline comes out of reset all-zero, so a button held through reset
    // would look like a fresh press once it reaches r_sync. Edges are ignored
    // until the pipeline has been refilled from the live inputs; a held button
    // then needs a release and a new press to register.
    assign o_rise = (r_sync & ~r_prev) & {WIDTH{r_arm[2]}};

endmodule

// File: rtl/elevator_request_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_request_scheduler
// Captures hall/car call buttons into a pending-request register, selects the
// next target with a SCAN (collective-direction) policy, drives the target to
// the elevator state machine, clears requests as they are served and holds the
// door open for a dwell period at every stop.
//
// Ports:
//   clk                - clock
//   rst_n              - asynchronous active-low reset
//   i_call_btn         - raw button levels, bit i = floor i
//   i_current_floor    - floor reported by the elevator controller
//   i_elevator_idle    - elevator controller not moving
//   o_requested_floor  - target floor to the elevator controller
//   o_pending          - outstanding requests
//   o_door_open        - high during dwell
//   o_dir_down         - SCAN direction (0 = up, 1 = down)
//   o_busy             - scheduler not idle
// ---------------------------------------------------------------------------
module elevator_request_scheduler #(
    parameter int          NUM_FLOORS  = 10,
    parameter int          FLOOR_W     = elevator_pkg::FLOOR_W,
    parameter logic [31:0] DWELL_COUNT = 32'd50000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] i_call_btn,
    input  logic [FLOOR_W-1:0]    i_current_floor,
    input  logic                  i_elevator_idle,
    output logic [FLOOR_W-1:0]    o_requested_floor,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_door_open,
    output logic                  o_dir_down,
    output logic                  o_busy
);

    import elevator_pkg::*;

    state_t                r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [FLOOR_W-1:0]    r_req;
    logic                  r_door;
    logic                  r_dir;
    logic                  r_busy;
    logic [31:0]           r_dwell_cnt;

    logic [NUM_FLOORS-1:0] w_rise;
    logic [NUM_FLOORS-1:0] w_cur_oh;
    logic [NUM_FLOORS-1:0] w_tgt_oh;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_pending_nxt;
    logic                  w_here;
    logic                  w_edge_here;
    logic                  w_have_above;
    logic                  w_have_below;
    logic [FLOOR_W-1:0]    w_above;
    logic [FLOOR_W-1:0]    w_below;
    logic                  w_arrive;
    logic                  w_dwell_done;

    button_sync_edge #(
        .WIDTH (NUM_FLOORS)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (i_call_btn),
        .o_rise (w_rise)
    );

    // Floor search. A current_floor outside the served range matches no bit,
    // so here stays 0 while above/below still resolve against it.
    always_comb begin
        w_cur_oh     = '0;
        w_tgt_oh     = '0;
        w_here       = 1'b0;
        w_edge_here  = 1'b0;
        w_have_above = 1'b0;
        w_have_below = 1'b0;
        w_above      = '0;
        w_below      = '0;
        // Descending scan: the last hit is the lowest floor above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && (FLOOR_W'(i) > i_current_floor)) begin
                w_have_above = 1'b1;
                w_above      = FLOOR_W'(i);
            end
        end
        // Ascending scan: the last hit is the highest floor below.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i] && (FLOOR_W'(i) < i_current_floor)) begin
                w_have_below = 1'b1;
                w_below      = FLOOR_W'(i);
            end
            w_cur_oh[i] = (FLOOR_W'(i) == i_current_floor);
            w_tgt_oh[i] = (FLOOR_W'(i) == r_req);
        end
        w_here      = |(r_pending & w_cur_oh);
        w_edge_here = |(w_rise & w_cur_oh);
    end

    assign w_arrive     = (i_current_floor == r_req) && i_elevator_idle;
    assign w_dwell_done = (r_dwell_cnt == DWELL_COUNT - 32'd1);

    // Pending update: new edges set, served floors clear, clear wins per bit.
    // While idle, a press at the current floor is served straight away, so it
    // is cleared in the same cycle it would otherwise have become visible.
    // While the door is open, a press at that floor only extends the dwell.
    always_comb begin
        w_set = w_rise;
        w_clr = '0;
        case (r_state)
            IDLE: begin
                if (w_here || w_edge_here) begin
                    w_clr = w_cur_oh;
                end
            end
            SERVE: begin
                if (w_arrive) begin
                    w_clr = w_tgt_oh;
                end
            end
            DWELL: begin
                w_set = w_rise & ~w_cur_oh;
            end
            default: begin
                w_set = w_rise;
            end
        endcase
        w_pending_nxt = (r_pending | w_set) & ~w_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_req       <= '0;
            r_door      <= 1'b0;
            r_dir       <= DIR_UP;
            r_busy      <= 1'b0;
            r_dwell_cnt <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            case (r_state)
                IDLE: begin
                    // Keep the elevator parked where it is.
                    r_req <= i_current_floor;
                    if (w_here || w_edge_here) begin
                        r_state     <= DWELL;
                        r_door      <= 1'b1;
                        r_busy      <= 1'b1;
                        r_dwell_cnt <= '0;
                    end else if ((r_dir == DIR_UP) && w_have_above) begin
                        r_state <= SERVE;
                        r_req   <= w_above;
                        r_busy  <= 1'b1;
                    end else if (w_have_below) begin
                        r_state <= SERVE;
                        r_req   <= w_below;
                        r_dir   <= DIR_DOWN;
                        r_busy  <= 1'b1;
                    end else if (w_have_above) begin
                        r_state <= SERVE;
                        r_req   <= w_above;
                        r_dir   <= DIR_UP;
                        r_busy  <= 1'b1;
                    end
                end
                SERVE: begin
                    if (w_arrive) begin
                        r_state     <= DWELL;
                        r_door      <= 1'b1;
                        r_dwell_cnt <= '0;
                    end else if ((r_dir == DIR_UP) && w_have_above && (w_above < r_req)) begin
                        // Closer stop in the direction of travel.
                        r_req <= w_above;
                    end else if ((r_dir == DIR_DOWN) && w_have_below && (w_below > r_req)) begin
                        r_req <= w_below;
                    end
                end
                DWELL: begin
                    if (w_edge_here) begin
                        r_dwell_cnt <= '0;
                    end else if (w_dwell_done) begin
                        r_state <= IDLE;
                        r_door  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_door  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_requested_floor = r_req;
    assign o_pending         = r_pending;
    assign o_door_open       = r_door;
    assign o_dir_down        = r_dir;
    assign o_busy            = r_busy;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// ---------------------------------------------------------------------------
// Bench for elevator_request_scheduler: NUM_FLOORS=10, DWELL_COUNT=4, with a
// simple elevator that moves one floor per 8 cycles toward requested_floor.
// ---------------------------------------------------------------------------
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int FW = 4;
    localparam int DW = 4;
    localparam int MOVE_CYC = 8;

    localparam int M_PARKED  = 0;
    localparam int M_MOVING  = 1;
    localparam int M_DOOR    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] call_btn;
    logic [FW-1:0] current_floor;
    logic          elevator_idle;
    logic [FW-1:0] requested_floor;
    logic [NF-1:0] pending;
    logic          door_open;
    logic          dir_down;
    logic          busy;

    int checks = 0;
    int errors = 0;

    elevator_request_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DWELL_COUNT (32'd4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_call_btn        (call_btn),
        .i_current_floor   (current_floor),
        .i_elevator_idle   (elevator_idle),
        .o_requested_floor (requested_floor),
        .o_pending         (pending),
        .o_door_open       (door_open),
        .o_dir_down        (dir_down),
        .o_busy            (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    bit      m_pend [NF];
    int      m_req;
    bit      m_down;
    bit      m_door;
    int      m_mode;
    int      m_dwell;
    bit [NF-1:0] lv1, lv2, lv3;   // button levels seen at the last three edges
    int      m_edges;

    task automatic model_reset();
        foreach (m_pend[f]) m_pend[f] = 1'b0;
        m_req   = 0;
        m_down  = 1'b0;
        m_door  = 1'b0;
        m_mode  = M_PARKED;
        m_dwell = 0;
        lv1 = '0; lv2 = '0; lv3 = '0;
        m_edges = 0;
    endtask

    task automatic model_step();
        bit [NF-1:0] press;
        bit [NF-1:0] blocked;
        int cur, above, below, clear_f;
        bit here, press_here;
        press   = (m_edges >= 3) ? (lv2 & ~lv3) : '0;
        blocked = '0;
        clear_f = -1;
        cur     = int'(current_floor);
        above   = -1;
        below   = -1;
        for (int f = 0; f < NF; f++) begin
            if (m_pend[f] && f > cur && above < 0) above = f;
            if (m_pend[f] && f < cur) below = f;
        end
        here       = (cur < NF) ? m_pend[cur] : 1'b0;
        press_here = (cur < NF) ? press[cur] : 1'b0;
        if (m_mode == M_PARKED) begin
            m_req = cur;
            if (here || press_here) begin
                clear_f = cur; m_mode = M_DOOR; m_door = 1'b1; m_dwell = 0;
            end else if (!m_down && above >= 0) begin
                m_req = above; m_mode = M_MOVING;
            end else if (below >= 0) begin
                m_req = below; m_down = 1'b1; m_mode = M_MOVING;
            end else if (above >= 0) begin
                m_req = above; m_down = 1'b0; m_mode = M_MOVING;
            end
        end else if (m_mode == M_MOVING) begin
            if (cur == m_req && elevator_idle) begin
                clear_f = m_req; m_mode = M_DOOR; m_door = 1'b1; m_dwell = 0;
            end else if (!m_down && above >= 0 && above < m_req) begin
                m_req = above;
            end else if (m_down && below >= 0 && below > m_req) begin
                m_req = below;
            end
        end else begin
            if (cur < NF) blocked[cur] = 1'b1;
            if (press_here) m_dwell = 0;
            else if (m_dwell == DW - 1) begin m_mode = M_PARKED; m_door = 1'b0; end
            else m_dwell++;
        end
        for (int f = 0; f < NF; f++)
            if (press[f] && !blocked[f]) m_pend[f] = 1'b1;
        if (clear_f >= 0) m_pend[clear_f] = 1'b0;
        lv3 = lv2; lv2 = lv1; lv1 = call_btn;
        if (m_edges < 3) m_edges++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- elevator environment ----------------
    int env_floor = 0;
    int env_timer = 0;

    task automatic env_update();
        if (int'(requested_floor) != env_floor) begin
            env_timer++;
            if (env_timer >= MOVE_CYC) begin
                env_timer = 0;
                env_floor += (int'(requested_floor) > env_floor) ? 1 : -1;
            end
        end else begin
            env_timer = 0;
        end
        current_floor = FW'(env_floor);
        elevator_idle = (env_floor == int'(requested_floor));
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit [NF-1:0] mp;
        for (int f = 0; f < NF; f++) mp[f] = m_pend[f];
        checks++;
        if (int'(requested_floor) != m_req || pending != mp || door_open != m_door ||
            dir_down != m_down || busy != (m_mode != M_PARKED)) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual req=%0d pend=%h door=%0b down=%0b busy=%0b required req=%0d pend=%h door=%0b down=%0b busy=%0b",
                     $time, requested_floor, pending, door_open, dir_down, busy,
                     m_req, mp, m_door, m_down, (m_mode != M_PARKED));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        compare_model();
        env_update();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_door(input bit val, input int budget, input string name);
        int n = 0;
        while (door_open != val && n < budget) begin tick(); n++; end
        check(name, int'(door_open), int'(val));
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (door_open && n < 40) begin n++; tick(); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        call_btn = '0;
        current_floor = '0;
        elevator_idle = 1'b1;
        #1;
        check("reset_req",  int'(requested_floor), 0);
        check("reset_pend", int'(pending), 0);
        check("reset_door", int'(door_open), 0);
        check("reset_busy", int'(busy) + int'(dir_down), 0);
        ticks(3);
        rst_n = 1'b1;
        ticks(5);

        // Single call from floor 0.
        call_btn[3] = 1'b1;
        ticks(3);
        check("btn3_pending", int'(pending), 'h008);
        call_btn[3] = 1'b0;
        tick();
        check("btn3_req", int'(requested_floor), 3);
        check("btn3_dir", int'(dir_down), 0);
        wait_door(1'b1, 200, "btn3_door_open");
        check("btn3_floor", env_floor, 3);
        check("btn3_cleared", int'(pending), 0);
        count_door(n);
        check("btn3_dwell_len", n, DW);
        check("btn3_idle", int'(busy), 0);

        // Intermediate stop picked up while travelling up.
        call_btn[7] = 1'b1;
        ticks(3);
        call_btn[7] = 1'b0;
        n = 0;
        while (env_floor != 4 && n < 200) begin tick(); n++; end
        check("reach_floor4", env_floor, 4);
        call_btn[6] = 1'b1;
        ticks(3);
        call_btn[6] = 1'b0;
        tick();
        check("retarget_6", int'(requested_floor), 6);
        wait_door(1'b1, 200, "stop6_door");
        check("stop6_floor", env_floor, 6);
        wait_door(1'b0, 20, "stop6_close");
        wait_door(1'b1, 200, "stop7_door");
        check("stop7_floor", env_floor, 7);
        wait_door(1'b0, 20, "stop7_close");

        // Simultaneous calls above and below while heading up.
        call_btn[2] = 1'b1;
        call_btn[8] = 1'b1;
        ticks(4);
        call_btn[2] = 1'b0;
        call_btn[8] = 1'b0;
        check("up_first_req", int'(requested_floor), 8);
        check("up_first_dir", int'(dir_down), 0);
        wait_door(1'b1, 200, "stop8_door");
        check("stop8_floor", env_floor, 8);
        wait_door(1'b0, 20, "stop8_close");
        tick();
        check("reverse_dir", int'(dir_down), 1);
        check("reverse_req", int'(requested_floor), 2);
        wait_door(1'b1, 200, "stop2_door");
        check("stop2_floor", env_floor, 2);
        wait_door(1'b0, 20, "stop2_close");

        // Press at the parked floor, then a repeat press during the dwell.
        call_btn[2] = 1'b1;
        tick();
        call_btn[2] = 1'b0;
        tick();
        call_btn[2] = 1'b1;
        tick();
        check("here_door", int'(door_open), 1);
        check("here_no_pend", int'(pending), 0);
        count_door(n);
        check("repulse_dwell_len", n, 6);
        check("repulse_pend", int'(pending), 0);
        call_btn[2] = 1'b0;
        ticks(2);

        // Random traffic against the reference.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                int b;
                b = $urandom_range(0, NF - 1);
                call_btn[b] = ~call_btn[b];
            end
            tick();
        end
        call_btn = '0;
        n = 0;
        while ((busy || pending != '0) && n < 4000) begin tick(); n++; end
        check("drain_pend", int'(pending), 0);
        check("drain_busy", int'(busy), 0);

        // Asynchronous reset in the middle of a trip with a button held.
        env_floor = 0;
        env_timer = 0;
        ticks(4);
        call_btn[6] = 1'b1;
        n = 0;
        while (!(busy && !door_open) && n < 50) begin tick(); n++; end
        check("mid_serve", int'(busy), 1);
        ticks(3);
        rst_n = 1'b0;
        #1;
        check("arst_req",  int'(requested_floor), 0);
        check("arst_pend", int'(pending), 0);
        check("arst_flags", int'(door_open) + int'(dir_down) + int'(busy), 0);
        env_floor = 0;
        env_timer = 0;
        ticks(3);
        rst_n = 1'b1;
        ticks(20);
        check("held_no_req", int'(pending), 0);
        call_btn[6] = 1'b0;
        ticks(3);
        call_btn[6] = 1'b1;
        ticks(3);
        check("repress_req", int'(pending), 'h040);
        call_btn[6] = 1'b0;
        ticks(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
- Initiator side of the elevator floor-request interface.
- Captures hall/car call buttons for each floor and keeps a pending-request register.
- Runs a SCAN (collective-direction) policy and drives requested_floor into elevator_state_machine.
- Watches current_floor and the elevator idle flag, clears a request when it is served, and holds the door open for a dwell period before scheduling the next target.

Parameters:
- NUM_FLOORS, 10, number of served floors (max 16).
- FLOOR_W, 4, width of floor numbers.
- DWELL_COUNT, 32'd50000000, cycles door_open stays high per stop (bench uses 4).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- call_btn  input  NUM_FLOORS  raw asynchronous button levels, bit i = floor i
- current_floor  input  FLOOR_W  floor reported by elevator controller
- elevator_idle  input  1  elevator controller idle flag (1 = not moving)
- requested_floor  output  FLOOR_W  target floor to elevator controller
- pending  output  NUM_FLOORS  outstanding requests
- door_open  output  1  high during dwell
- dir_down  output  1  SCAN direction, 0 = up, 1 = down
- busy  output  1  state != IDLE

Behaviour:
- Reset values: requested_floor=0, pending=0, door_open=0, dir_down=0, busy=0, state=IDLE, dwell counter=0, sync flops=0.
- Button capture:
  - 2-flop synchronizer per bit, then rising-edge detect.
  - pending[i] sets on the cycle the edge is detected, i.e. 3 clk edges after call_btn[i] rises.
  - Held buttons do not retrigger.
- Combinational search on pending and current_floor:
  - here = pending[current_floor].
  - above = lowest set index > current_floor; have_above flag.
  - below = highest set index < current_floor; have_below flag.
  - current_floor >= NUM_FLOORS: here=0, above/below computed normally.
- State IDLE (requested_floor <= current_floor each cycle, so the elevator holds):
  - priority 1, here: clear pending[current_floor], go DWELL.
  - priority 2, dir up and have_above: target=above, go SERVE.
  - priority 3, have_below: dir_down=1, target=below, go SERVE.
  - priority 4, have_above: dir_down=0, target=above, go SERVE.
  - otherwise stay IDLE.
- State SERVE:
  - requested_floor=target, registered, valid the cycle after entry.
  - Retarget every cycle: dir up and have_above and above<target -> target=above; dir down and have_below and below>target -> target=below. This picks up intermediate stops along the direction of travel.
  - Arrival: current_floor==target and elevator_idle==1 -> clear pending[target], go DWELL.
  - A new edge for the target floor in the same cycle as the arrival clear: clear wins.
  - Set/clear of different bits in one cycle both take effect.
- State DWELL:
  - door_open=1; counter counts 0..DWELL_COUNT-1, then go IDLE with door_open=0 the next cycle.
  - New edge on current_floor's button during DWELL restarts the counter and does not set pending.
  - Other floors set pending normally.
  - requested_floor is held.
- Direction changes only in IDLE.
- Async reset mid-operation: everything returns to reset values immediately and all pending requests are dropped.
- requested_floor never exceeds NUM_FLOORS-1 while SERVE.

Decomposition:
- Package elevator_pkg:
  - FLOOR_W.
  - State encoding: IDLE=2'b00, SERVE=2'b01, DWELL=2'b10.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - Shared with elevator_state_machine for floor width.
- Sub-module button_sync_edge, parameterised width: synchronizer plus rising-edge pulse vector.
- Search logic and FSM stay in the top module.

Test Plan (NUM_FLOORS=10, DWELL_COUNT=4; elevator model moves one floor per 8 cycles):
- Reset, press btn[3] from floor 0:
  - pending=0x008 after 3 cycles.
  - requested_floor=3 and dir_down=0.
  - On arrival with idle: pending=0, door_open high exactly 4 cycles, then busy=0.
- Target 7 from floor 0, press btn[4] while at floor 2:
  - target retargets to 4.
  - Stops at 4 (dwell), then serves 7.
- At floor 5 idle, dir up, press btn[2] and btn[8] same cycle: serves 8 first (up priority), then dir_down=1 and serves 2.
- Press btn[current_floor] while idle: no SERVE, immediate DWELL, pending bit cleared the same cycle it would have been visible.
- During DWELL at floor 4, repulse btn[4] at dwell cycle 2: door_open stays high for 4 more cycles and pending[4] remains 0.
- Hold btn[6], assert rst_n=0 mid-SERVE: all outputs return to reset values asynchronously; after release, the held button does not create a request until released and pressed again.
